// File: rtl/systolic_array_pkg.sv
// Shared types and sizing for the systolic array and its scratchpad.
package systolic_array_pkg;

    localparam int unsigned WORD_W           = 32;
    localparam int unsigned ADDR_W           = 32;
    localparam int unsigned SCRATCHPAD_DEPTH = 256;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        SP_CLEAR = 1'b0,
        SP_READY = 1'b1
    } sp_state_t;

endpackage

// File: rtl/scratchpad_bank.sv
// One scratchpad bank: DEPTH words, registered x/w read ports, one write port.
// Optional same-edge write-to-read forwarding under SCRATCHPAD_BYPASS_EN.
module scratchpad_bank
    import systolic_array_pkg::*;
#(
    parameter  int unsigned DEPTH = SCRATCHPAD_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_x_idx,
    input  logic [AW-1:0] i_w_idx,
    input  logic          i_we,
    input  logic [AW-1:0] i_wr_idx,
    input  word_t         i_wr_data,
    output word_t         o_x_data,
    output word_t         o_w_data
);

    word_t r_mem [DEPTH];
    word_t r_x_data;
    word_t r_w_data;

    // Storage is left unreset; the sweep in the parent zeroes it.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_data <= '0;
            r_w_data <= '0;
        end else if (i_rd_en) begin
`ifdef SCRATCHPAD_BYPASS_EN
            r_x_data <= (i_we && (i_wr_idx == i_x_idx)) ? i_wr_data : r_mem[i_x_idx];
            r_w_data <= (i_we && (i_wr_idx == i_w_idx)) ? i_wr_data : r_mem[i_w_idx];
`else
            r_x_data <= r_mem[i_x_idx];
            r_w_data <= r_mem[i_w_idx];
`endif
        end
    end

    assign o_x_data = r_x_data;
    assign o_w_data = r_w_data;

endmodule

// File: rtl/scratchpad_banks.sv
// Lane-banked scratchpad with a zeroing sweep after reset or on clear_req.
// Build option: SCRATCHPAD_BYPASS_EN forwards same-edge writes to reads.
module scratchpad_banks
    import systolic_array_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = SCRATCHPAD_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             sc_valid_queue,
    input  logic [N-1:0][ADDR_W-1:0] sc_x_queue,
    input  logic [N-1:0][ADDR_W-1:0] sc_w_queue,
    input  logic [N-1:0]             sc_valid_write,
    input  logic [N-1:0][ADDR_W-1:0] sc_write_queue,
    input  logic [N-1:0][WORD_W-1:0] sc_write_data,
    input  logic                     clear_req,
    output word_t [N-1:0]            sc_x_data,
    output word_t [N-1:0]            sc_w_data,
    output logic  [N-1:0]            sc_data_valid,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    sp_state_t     r_state;
    sp_state_t     w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic          r_busy;
    logic [N-1:0]  r_valid;
    logic [N-1:0]  w_rd_en;
    logic          w_clearing;
    logic          w_unused_addr;

    assign w_clearing = (r_state == SP_CLEAR);
    assign w_rd_en    = w_clearing ? '0 : sc_valid_queue;

    // Only the word-index bits of each address reach the banks.
    assign w_unused_addr = ^{sc_x_queue, sc_w_queue, sc_write_queue};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SP_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_valid <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == SP_CLEAR);
            r_valid <= w_rd_en;
        end
    end

    // Sweep one entry per cycle; a clear_req mid-sweep is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            SP_CLEAR: begin
                w_cnt_nxt = r_cnt + AW'(1);
                if (r_cnt == AW'(DEPTH - 1)) begin
                    w_state_nxt = SP_READY;
                end
            end
            SP_READY: begin
                if (clear_req) begin
                    w_state_nxt = SP_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = SP_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_bank
        logic          w_we;
        logic [AW-1:0] w_wr_idx;
        word_t         w_wr_data;

        assign w_we      = w_clearing | sc_valid_write[gi];
        assign w_wr_idx  = w_clearing ? r_cnt : sc_write_queue[gi][AW+1:2];
        assign w_wr_data = w_clearing ? '0 : sc_write_data[gi];

        scratchpad_bank #(
            .DEPTH (DEPTH)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .i_rd_en   (w_rd_en[gi]),
            .i_x_idx   (sc_x_queue[gi][AW+1:2]),
            .i_w_idx   (sc_w_queue[gi][AW+1:2]),
            .i_we      (w_we),
            .i_wr_idx  (w_wr_idx),
            .i_wr_data (w_wr_data),
            .o_x_data  (sc_x_data[gi]),
            .o_w_data  (sc_w_data[gi])
        );
    end

    assign sc_data_valid = r_valid;
    assign busy          = r_busy;

endmodule

// File: tb/tb_scratchpad_banks.sv
// Scoreboard bench for scratchpad_banks: directed reads/writes, sweep timing, clear and reset.
module tb_scratchpad_banks;

    localparam int N = 4;

`ifdef SCRATCHPAD_BYPASS_EN
    localparam logic [31:0] BYP_X = 32'hA5A5A5A5;
`else
    localparam logic [31:0] BYP_X = 32'h00000001;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0]        sc_valid_queue;
    logic [N-1:0][31:0]  sc_x_queue;
    logic [N-1:0][31:0]  sc_w_queue;
    logic [N-1:0]        sc_valid_write;
    logic [N-1:0][31:0]  sc_write_queue;
    logic [N-1:0][31:0]  sc_write_data;
    logic                clear_req;
    logic [N-1:0][31:0]  sc_x_data;
    logic [N-1:0][31:0]  sc_w_data;
    logic [N-1:0]        sc_data_valid;
    logic                busy;

    typedef struct {
        logic [N-1:0]       mask;
        logic [N-1:0][31:0] x;
        logic [N-1:0][31:0] w;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    scratchpad_banks #(.N(N), .DEPTH(256)) dut (
        .clk            (clk),
        .rst            (rst),
        .sc_valid_queue (sc_valid_queue),
        .sc_x_queue     (sc_x_queue),
        .sc_w_queue     (sc_w_queue),
        .sc_valid_write (sc_valid_write),
        .sc_write_queue (sc_write_queue),
        .sc_write_data  (sc_write_data),
        .clear_req      (clear_req),
        .sc_x_data      (sc_x_data),
        .sc_w_data      (sc_w_data),
        .sc_data_valid  (sc_data_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sc_valid_queue = '0;
        sc_x_queue     = '0;
        sc_w_queue     = '0;
        sc_valid_write = '0;
        sc_write_queue = '0;
        sc_write_data  = '0;
        clear_req      = 1'b0;
    endtask

    // Apply the currently driven inputs for one edge, recording any expected read response.
    task automatic issue(input logic [N-1:0][31:0] xe, input logic [N-1:0][31:0] we);
        exp_t e;
        if (sc_valid_queue != '0) begin
            e.mask = sc_valid_queue;
            e.x    = xe;
            e.w    = we;
            exp_q.push_back(e);
        end
        tick();
        clear_inputs();
    endtask

    task automatic count_busy(input int clr_at, output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            clear_req = (n == clr_at);
            n++;
            tick();
        end
        clear_req = 1'b0;
    endtask

    // Monitor: every valid response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && sc_data_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(sc_data_valid), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("valid_mask", 32'(sc_data_valid), 32'(e.mask));
                for (int i = 0; i < N; i++) begin
                    if (e.mask[i]) begin
                        check($sformatf("x_data_lane%0d", i), sc_x_data[i], e.x[i]);
                        check($sformatf("w_data_lane%0d", i), sc_w_data[i], e.w[i]);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_valid", 32'(sc_data_valid), 32'h0);
        check("rst_x_data0", sc_x_data[0], 32'h0);
        check("rst_w_data3", sc_w_data[3], 32'h0);
        rst = 1'b0;

        // Initial sweep, with a lane 2 read that must be dropped.
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            if (n == 10) begin
                sc_valid_queue[2] = 1'b1;
                sc_x_queue[2]     = 32'h3FC;
                sc_w_queue[2]     = 32'h3FC;
            end else begin
                sc_valid_queue = '0;
            end
            if (n == 11) check("busy_read_valid", 32'(sc_data_valid), 32'h0);
            n++;
            tick();
        end
        clear_inputs();
        check("sweep_busy_cycles", 32'(n), 32'd256);

        // Write then read lane 1.
        sc_valid_write[1] = 1'b1; sc_write_queue[1] = 32'h10; sc_write_data[1] = 32'hDEADBEEF;
        issue('0, '0);
        sc_valid_queue = 4'b0010; sc_x_queue[1] = 32'h10; sc_w_queue[1] = 32'h14;
        issue({32'h0, 32'h0, 32'hDEADBEEF, 32'h0}, '0);
        tick();
        check("hold_valid", 32'(sc_data_valid), 32'h0);
        check("hold_x_data1", sc_x_data[1], 32'hDEADBEEF);

        // Address wrap at DEPTH words.
        sc_valid_write[0] = 1'b1; sc_write_queue[0] = 32'h400; sc_write_data[0] = 32'h12345678;
        issue('0, '0);
        sc_valid_queue = 4'b0001; sc_x_queue[0] = 32'h000; sc_w_queue[0] = 32'h400;
        issue({32'h0, 32'h0, 32'h0, 32'h12345678}, {32'h0, 32'h0, 32'h0, 32'h12345678});

        // Same-edge write and read on lane 3.
        sc_valid_write[3] = 1'b1; sc_write_queue[3] = 32'h20; sc_write_data[3] = 32'h1;
        issue('0, '0);
        sc_valid_write[3] = 1'b1; sc_write_queue[3] = 32'h20; sc_write_data[3] = 32'hA5A5A5A5;
        sc_valid_queue = 4'b1000; sc_x_queue[3] = 32'h20; sc_w_queue[3] = 32'h24;
        issue({BYP_X, 32'h0, 32'h0, 32'h0}, '0);
        sc_valid_queue = 4'b1000; sc_x_queue[3] = 32'h20; sc_w_queue[3] = 32'h20;
        issue({32'hA5A5A5A5, 32'h0, 32'h0, 32'h0}, {32'hA5A5A5A5, 32'h0, 32'h0, 32'h0});

        // All lanes at once, ignored low and high address bits.
        sc_valid_write = 4'b1111;
        sc_write_queue = {32'h40, 32'h440, 32'h40, 32'h40};
        sc_write_data  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        issue('0, '0);
        sc_valid_queue = 4'b1111;
        sc_x_queue = {32'hFFFFF840, 32'h43, 32'h40, 32'h40};
        sc_w_queue = {32'h20, 32'h44, 32'h10, 32'h0};
        issue({32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
              {32'hA5A5A5A5, 32'h0, 32'hDEADBEEF, 32'h12345678});

        // clear_req with a same-edge read and write, re-pulsed mid-sweep.
        clear_req = 1'b1;
        sc_valid_write[2] = 1'b1; sc_write_queue[2] = 32'h80; sc_write_data[2] = 32'hCAFEF00D;
        sc_valid_queue = 4'b0001; sc_x_queue[0] = 32'h0; sc_w_queue[0] = 32'h0;
        issue({32'h0, 32'h0, 32'h0, 32'h12345678}, {32'h0, 32'h0, 32'h0, 32'h12345678});
        count_busy(50, n);
        check("clear_busy_cycles", 32'(n), 32'd256);
        check("clear_x_data0_held", sc_x_data[0], 32'h12345678);

        sc_valid_queue = 4'b0110;
        sc_x_queue[2] = 32'h80; sc_w_queue[2] = 32'h40;
        sc_x_queue[1] = 32'h10; sc_w_queue[1] = 32'h40;
        issue('0, '0);

        // Reset at sweep cycle 100 clears outputs and restarts the sweep.
        clear_req = 1'b1;
        issue('0, '0);
        repeat (100) tick();
        check("mid_sweep_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #2;
        check("mid_rst_x_data0", sc_x_data[0], 32'h0);
        check("mid_rst_w_data0", sc_w_data[0], 32'h0);
        check("mid_rst_valid", 32'(sc_data_valid), 32'h0);
        tick();
        rst = 1'b0;
        count_busy(-1, n);
        check("rst_restart_busy_cycles", 32'(n), 32'd256);

        sc_valid_queue = 4'b1001;
        sc_x_queue[0] = 32'h0;  sc_w_queue[0] = 32'h400;
        sc_x_queue[3] = 32'h20; sc_w_queue[3] = 32'h40;
        issue('0, '0);
        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
